hit_strike_generator: RTL and testbench

- Frame-synchronised collision arbiter; produces the one-cycle `strike` pulse consumed by the lives display.
- Takes the pacman and ghost drawingRequest outputs from the object bitmaps and accumulates pixel overlaps over one frame.
- At each frame boundary, issues at most one event: either a strike (pacman hit) or a ghostEaten pulse (power mode).
- Provides a post-hit invulnerability window with a blink control, and freezes permanently on game over.

---
 rtl/hit_strike_generator.sv | 122 ++++++++++++
 tb/tb_hit_strike_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_strike_generator.sv
// Frame-synchronised pacman/ghost collision arbiter: latches overlaps per frame, issues one strike or ghostEaten per frame.
// Latency 1 cycle from startOfFrame to result pulses; no backpressure, pulses are fire-and-forget.
module hit_strike_generator #(
    parameter int NUM_GHOSTS      = 4,
    parameter int COOLDOWN_FRAMES = 90,
    parameter int BLINK_LOG2      = 3,
    parameter int MAX_LIVES       = 3
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  pacmanDR,
    input  logic [NUM_GHOSTS-1:0] ghostDR,
    input  logic                  powerMode,
    input  logic                  gameOver,
    output logic                  strike,
    output logic                  respawn,
    output logic                  ghostEaten,
    output logic [1:0]            ghostEatenId,
    output logic                  invulnerable,
    output logic                  pacmanVisible,
    output logic                  frozen
);

    typedef enum logic [1:0] {ARMED, COOLDOWN, DEAD} state_t;

    localparam logic [7:0] CD_RELOAD = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [1:0] LIVES     = 2'(MAX_LIVES);

    state_t                state, state_nxt;
    logic [NUM_GHOSTS-1:0] hit_latch, hit_latch_nxt, overlap;
    logic [1:0]            strike_cnt, strike_cnt_nxt, cnt_inc;
    logic [7:0]            cd_cnt, cd_cnt_nxt;
    logic                  any_hit, eval;
    logic                  strike_nxt, ghost_eaten_nxt;
    logic [1:0]            lowest_id, ghost_eaten_id_nxt;

    assign overlap = {NUM_GHOSTS{pacmanDR}} & ghostDR;
    assign any_hit = |hit_latch;
    assign eval    = startOfFrame && !gameOver;
    assign cnt_inc = (strike_cnt == 2'd3) ? 2'd3 : strike_cnt + 2'd1;

    always_comb begin
        lowest_id = 2'd0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (hit_latch[i]) lowest_id = 2'(i);
        end
    end

    // State register plus frame-level bookkeeping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ARMED;
            hit_latch    <= '0;
            strike_cnt   <= 2'd0;
            cd_cnt       <= 8'd0;
            strike       <= 1'b0;
            respawn      <= 1'b0;
            ghostEaten   <= 1'b0;
            ghostEatenId <= 2'd0;
        end else begin
            state        <= state_nxt;
            hit_latch    <= hit_latch_nxt;
            strike_cnt   <= strike_cnt_nxt;
            cd_cnt       <= cd_cnt_nxt;
            strike       <= strike_nxt;
            respawn      <= strike_nxt;
            ghostEaten   <= ghost_eaten_nxt;
            ghostEatenId <= ghost_eaten_id_nxt;
        end
    end

    // gameOver wins over any same-cycle evaluation.
    always_comb begin
        state_nxt      = state;
        cd_cnt_nxt     = cd_cnt;
        strike_cnt_nxt = strike_cnt;
        if (gameOver) begin
            state_nxt = DEAD;
        end else begin
            case (state)
                ARMED: begin
                    if (startOfFrame && any_hit && !powerMode) begin
                        strike_cnt_nxt = cnt_inc;
                        if (cnt_inc == LIVES) begin
                            state_nxt = DEAD;
                        end else begin
                            state_nxt  = COOLDOWN;
                            cd_cnt_nxt = CD_RELOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cd_cnt == 8'd0) state_nxt = ARMED;
                        else                cd_cnt_nxt = cd_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // An overlap on the startOfFrame cycle is latched after the clear, so it counts for the next frame.
    always_comb begin
        hit_latch_nxt = '0;
        if (state_nxt == ARMED) begin
            hit_latch_nxt = startOfFrame ? overlap : (hit_latch | overlap);
        end
    end

    always_comb begin
        strike_nxt         = (state == ARMED) && eval && any_hit && !powerMode;
        ghost_eaten_nxt    = (state == ARMED) && eval && any_hit && powerMode;
        ghost_eaten_id_nxt = ghost_eaten_nxt ? lowest_id : 2'd0;
    end

    assign invulnerable  = (state == COOLDOWN);
    assign frozen        = (state == DEAD);
    assign pacmanVisible = (state == COOLDOWN) ? cd_cnt[BLINK_LOG2] : 1'b1;

endmodule

// File: tb/tb_hit_strike_generator.sv
// Directed bench: short-cooldown instance for timing/lives checks, default-parameter instance for the mid-cooldown reset case.
module tb_hit_strike_generator;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       pacmanDR;
    logic [3:0] ghostDR;
    logic       powerMode;
    logic       gameOver;

    logic       m_strike, m_respawn, m_ghostEaten, m_invulnerable, m_pacmanVisible, m_frozen;
    logic [1:0] m_ghostEatenId;
    logic       l_strike, l_respawn, l_ghostEaten, l_invulnerable, l_pacmanVisible, l_frozen;
    logic [1:0] l_ghostEatenId;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hit_strike_generator #(
        .NUM_GHOSTS(4), .COOLDOWN_FRAMES(4), .BLINK_LOG2(1), .MAX_LIVES(3)
    ) u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pacmanDR(pacmanDR),
        .ghostDR(ghostDR), .powerMode(powerMode), .gameOver(gameOver),
        .strike(m_strike), .respawn(m_respawn), .ghostEaten(m_ghostEaten),
        .ghostEatenId(m_ghostEatenId), .invulnerable(m_invulnerable),
        .pacmanVisible(m_pacmanVisible), .frozen(m_frozen)
    );

    hit_strike_generator #(
        .NUM_GHOSTS(4), .COOLDOWN_FRAMES(90), .BLINK_LOG2(3), .MAX_LIVES(3)
    ) u_dut_long (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pacmanDR(pacmanDR),
        .ghostDR(ghostDR), .powerMode(powerMode), .gameOver(gameOver),
        .strike(l_strike), .respawn(l_respawn), .ghostEaten(l_ghostEaten),
        .ghostEatenId(l_ghostEatenId), .invulnerable(l_invulnerable),
        .pacmanVisible(l_pacmanVisible), .frozen(l_frozen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at that same point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_overlap(input int n, input logic [3:0] g);
        pacmanDR = 1'b1;
        ghostDR  = g;
        repeat (n) cyc();
        pacmanDR = 1'b0;
        ghostDR  = 4'b0000;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
    endtask

    task automatic empty_frame();
        repeat (3) cyc();
        sof_pulse();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) cyc();
        resetN = 1'b1;
        cyc();
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pacmanDR     = 1'b0;
        ghostDR      = 4'b0000;
        powerMode    = 1'b0;
        gameOver     = 1'b0;
        repeat (2) cyc();
        check("rst_strike", 32'(m_strike), 32'd0);
        check("rst_respawn", 32'(m_respawn), 32'd0);
        check("rst_ghostEaten", 32'(m_ghostEaten), 32'd0);
        check("rst_ghostEatenId", 32'(m_ghostEatenId), 32'd0);
        check("rst_invulnerable", 32'(m_invulnerable), 32'd0);
        check("rst_pacmanVisible", 32'(m_pacmanVisible), 32'd1);
        check("rst_frozen", 32'(m_frozen), 32'd0);
        resetN = 1'b1;
        cyc();

        // Empty frame, then a 5-cycle overlap with ghost 2.
        empty_frame();
        check("empty_no_strike", 32'(m_strike), 32'd0);
        cyc();
        drive_overlap(5, 4'b0100);
        repeat (3) cyc();
        sof_pulse();
        check("hit1_strike", 32'(m_strike), 32'd1);
        check("hit1_respawn", 32'(m_respawn), 32'd1);
        check("hit1_invulnerable", 32'(m_invulnerable), 32'd1);
        check("hit1_visible_cnt3", 32'(m_pacmanVisible), 32'd1);
        check("hit1_long_strike", 32'(l_strike), 32'd1);
        cyc();
        check("hit1_strike_width", 32'(m_strike), 32'd0);
        check("hit1_respawn_width", 32'(m_respawn), 32'd0);

        // Continuous overlap through cooldown: counter 2,1,0 then ARMED, strike at 5th frame.
        pacmanDR = 1'b1;
        ghostDR  = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            repeat (3) cyc();
            sof_pulse();
            check($sformatf("cd_strike_f%0d", k), 32'(m_strike), (k == 5) ? 32'd1 : 32'd0);
            case (k)
                1: check("cd_visible_cnt2", 32'(m_pacmanVisible), 32'd1);
                2: check("cd_visible_cnt1", 32'(m_pacmanVisible), 32'd0);
                3: check("cd_visible_cnt0", 32'(m_pacmanVisible), 32'd0);
                4: begin
                    check("cd_armed_visible", 32'(m_pacmanVisible), 32'd1);
                    check("cd_armed_invuln", 32'(m_invulnerable), 32'd0);
                end
                default: check("hit2_invuln", 32'(m_invulnerable), 32'd1);
            endcase
        end
        check("long_no_strike_in_cd", 32'(l_strike), 32'd0);
        pacmanDR = 1'b0;
        ghostDR  = 4'b0000;
        repeat (4) empty_frame();
        check("after_cd2_invuln", 32'(m_invulnerable), 32'd0);

        // powerMode is sampled only at evaluation; ghosts 1 and 3 overlap.
        drive_overlap(3, 4'b1010);
        powerMode = 1'b1;
        cyc();
        sof_pulse();
        check("pm_ghostEaten", 32'(m_ghostEaten), 32'd1);
        check("pm_ghostEatenId", 32'(m_ghostEatenId), 32'd1);
        check("pm_no_strike", 32'(m_strike), 32'd0);
        check("pm_stays_armed", 32'(m_invulnerable), 32'd0);
        cyc();
        check("pm_pulse_width", 32'(m_ghostEaten), 32'd0);
        check("pm_id_cleared", 32'(m_ghostEatenId), 32'd0);
        empty_frame();
        check("pm_latch_discarded", 32'(m_ghostEaten), 32'd0);
        powerMode = 1'b0;

        // Third strike freezes; a fourth overlap is ignored.
        drive_overlap(3, 4'b0001);
        sof_pulse();
        check("hit3_strike", 32'(m_strike), 32'd1);
        check("hit3_frozen", 32'(m_frozen), 32'd1);
        cyc();
        check("hit3_strike_width", 32'(m_strike), 32'd0);
        drive_overlap(3, 4'b0001);
        sof_pulse();
        check("dead_no_strike", 32'(m_strike), 32'd0);
        check("dead_no_respawn", 32'(m_respawn), 32'd0);
        check("dead_frozen", 32'(m_frozen), 32'd1);

        // gameOver coincident with evaluation of a latched hit.
        do_reset();
        check("post_reset_unfrozen", 32'(m_frozen), 32'd0);
        drive_overlap(3, 4'b1000);
        gameOver = 1'b1;
        sof_pulse();
        gameOver = 1'b0;
        check("go_no_strike", 32'(m_strike), 32'd0);
        check("go_frozen", 32'(m_frozen), 32'd1);
        check("go_not_invuln", 32'(m_invulnerable), 32'd0);

        // Reset with the default-parameter instance at cooldown counter 40.
        do_reset();
        drive_overlap(3, 4'b0010);
        sof_pulse();
        check("long_hit_strike", 32'(l_strike), 32'd1);
        repeat (49) empty_frame();
        check("long_cd40_invuln", 32'(l_invulnerable), 32'd1);
        check("long_cd40_visible", 32'(l_pacmanVisible), 32'd1);
        check("long_cd40_no_strike", 32'(l_strike), 32'd0);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_invuln", 32'(l_invulnerable), 32'd0);
        check("async_rst_visible", 32'(l_pacmanVisible), 32'd1);
        check("async_rst_frozen", 32'(l_frozen), 32'd0);
        cyc();
        resetN = 1'b1;
        cyc();
        drive_overlap(3, 4'b0010);
        sof_pulse();
        check("long_post_rst_strike", 32'(l_strike), 32'd1);
        check("main_post_rst_strike", 32'(m_strike), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
